// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Load/store front end for a single-port data memory: computes base+offset,
// range-checks it, runs one single-cycle memory access and holds the response.
module mem_access_unit #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int EA_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t            state_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [EA_W-1:0]   ea_d;
    logic              ea_err_d;

    // Two guard bits keep the sum exact: the top bit is the sign, nothing wraps.
    assign ea_d     = {2'b00, req_base} + {{2{req_offset[ADDR_W-1]}}, req_offset};
    assign ea_err_d = ea_d[EA_W-1] || (ea_d >= EA_W'(MEM_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (ea_err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else if (req_write) begin
                            mem_addr_q  <= ea_d[ADDR_W-1:0];
                            mem_wdata_q <= req_wdata;
                            mem_we_q    <= 1'b1;
                            state_q     <= WRITE;
                        end else begin
                            mem_addr_q <= ea_d[ADDR_W-1:0];
                            mem_re_q   <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    mem_re_q     <= 1'b0;
                    resp_rdata_q <= mem_rdata;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                WRITE: begin
                    mem_we_q     <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Bench for mem_access_unit: directed vector table, randomized transactions
// against an arithmetic address/memory model, and a reset-during-store sequence.
module tb_mem_access_unit;

    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_base = '0;
    logic [ADDR_W-1:0] req_offset = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_base  (req_base),
        .req_offset(req_offset),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Attached memory device and the bench's own expectation of its contents.
    logic [DATA_W-1:0] dev_mem [MEM_DEPTH];
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];

    assign mem_rdata = (int'(mem_addr) < MEM_DEPTH) ? dev_mem[mem_addr[5:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < MEM_DEPTH) dev_mem[mem_addr[5:0]] = mem_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_en = 0;
    int seen_en = 0;
    int we_run = 0;
    int re_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Enable exclusivity and one-cycle pulse width, sampled every falling edge.
    always @(negedge clk) begin
        if (reset) begin
            we_run = 0;
            re_run = 0;
        end else begin
            chk("we_re_exclusive", 32'(mem_we && mem_re), 0);
            we_run = mem_we ? we_run + 1 : 0;
            re_run = mem_re ? re_run + 1 : 0;
            if (we_run == 1 || re_run == 1) seen_en++;
            chk("enable_pulse_width", 32'(we_run > 1 || re_run > 1), 0);
        end
    end

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] off;
        logic [DATA_W-1:0] wd;
        bit                err;
        logic [ADDR_W-1:0] addr;
        int                hold;
    } vec_t;

    task automatic run_txn(input string tag, input bit wr, input logic [7:0] base,
                           input logic [7:0] off, input logic [15:0] wd,
                           input bit exp_err, input logic [7:0] exp_addr, input int hold);
        logic [15:0] exp_rd;
        int lat;
        exp_rd = (wr || exp_err) ? 16'h0 : ref_mem[exp_addr[5:0]];
        @(negedge clk);
        chk({tag, "/req_ready"}, 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_base   = 8'($urandom);
        req_offset = 8'($urandom);
        req_wdata  = 16'($urandom);
        chk({tag, "/busy"}, 32'(busy), 1);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "/mem_we"}, 32'(mem_we), 32'(wr && !exp_err));
                chk({tag, "/mem_re"}, 32'(mem_re), 32'(!wr && !exp_err));
                if (!exp_err) chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(exp_addr));
                if (wr && !exp_err) chk({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(wd));
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "/latency"}, 32'(lat), exp_err ? 1 : 2);
        if (lat == 0) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
            return;
        end
        chk({tag, "/resp_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "/resp_rdata"}, 32'(resp_rdata), 32'(exp_rd));
        if (!exp_err) exp_en++;
        for (int k = 0; k < hold; k++) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_base   = 8'h00;
            req_offset = 8'h00;
            @(negedge clk);
            chk({tag, "/bp_valid"}, 32'(resp_valid), 1);
            chk({tag, "/bp_rdata"}, 32'(resp_rdata), 32'(exp_rd));
            chk({tag, "/bp_err"}, 32'(resp_err), 32'(exp_err));
            chk({tag, "/bp_ready"}, 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk({tag, "/resp_done"}, 32'(resp_valid), 0);
        chk({tag, "/idle"}, 32'(busy), 0);
        if (wr && !exp_err) begin
            ref_mem[exp_addr[5:0]] = wd;
            chk({tag, "/stored"}, 32'(dev_mem[exp_addr[5:0]]), 32'(wd));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        for (int i = 0; i < MEM_DEPTH; i++) begin
            dev_mem[i] = 16'((i * 16'h0457) ^ 16'h5A5A);
            ref_mem[i] = dev_mem[i];
        end

        #3;
        chk("rst/mem_we", 32'(mem_we), 0);
        chk("rst/mem_re", 32'(mem_re), 0);
        chk("rst/mem_addr", 32'(mem_addr), 0);
        chk("rst/mem_wdata", 32'(mem_wdata), 0);
        chk("rst/resp_valid", 32'(resp_valid), 0);
        chk("rst/resp_err", 32'(resp_err), 0);
        chk("rst/resp_rdata", 32'(resp_rdata), 0);
        chk("rst/busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst/req_ready", 32'(req_ready), 1);

        //            wr  base   off    wdata     err addr   hold
        vecs.push_back('{1'b1, 8'h02, 8'h01, 16'hBEEF, 1'b0, 8'h03, 0});
        vecs.push_back('{1'b0, 8'h02, 8'h01, 16'h0000, 1'b0, 8'h03, 0});
        vecs.push_back('{1'b0, 8'h05, 8'hFE, 16'h0000, 1'b0, 8'h03, 5});
        vecs.push_back('{1'b1, 8'h3F, 8'h01, 16'h1111, 1'b1, 8'h00, 0});
        vecs.push_back('{1'b0, 8'h00, 8'hFF, 16'h0000, 1'b1, 8'h00, 2});
        vecs.push_back('{1'b1, 8'h3F, 8'h00, 16'hCAFE, 1'b0, 8'h3F, 1});
        vecs.push_back('{1'b0, 8'h3F, 8'h00, 16'h0000, 1'b0, 8'h3F, 0});
        vecs.push_back('{1'b0, 8'h40, 8'h00, 16'h0000, 1'b1, 8'h00, 0});
        vecs.push_back('{1'b0, 8'h80, 8'h80, 16'h0000, 1'b0, 8'h00, 0});
        vecs.push_back('{1'b0, 8'hFF, 8'h7F, 16'h0000, 1'b1, 8'h00, 0});
        vecs.push_back('{1'b1, 8'hFF, 8'h81, 16'h7777, 1'b1, 8'h00, 0});
        vecs.push_back('{1'b0, 8'h01, 8'hFF, 16'h0000, 1'b0, 8'h00, 3});
        vecs.push_back('{1'b1, 8'h00, 8'h00, 16'hA5A5, 1'b0, 8'h00, 0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 0});

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].base, vecs[i].off,
                    vecs[i].wd, vecs[i].err, vecs[i].addr, vecs[i].hold);

        for (int i = 0; i < 60; i++) begin
            bit          wr;
            logic [7:0]  base;
            logic [7:0]  off;
            int          ea;
            bit          err;
            wr   = 1'($urandom);
            base = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
            off  = ($urandom % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 16) - 8);
            ea   = int'(base) + int'($signed(off));
            err  = (ea < 0) || (ea >= MEM_DEPTH);
            run_txn($sformatf("rnd%0d", i), wr, base, off, 16'($urandom), err,
                    err ? 8'h00 : 8'(ea), int'($urandom_range(0, 3)));
        end

        // Store aborted by reset between the accept edge and the write edge.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_base   = 8'h10;
        req_offset = 8'h00;
        req_wdata  = ~ref_mem[16];
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rstw/mem_we", 32'(mem_we), 0);
        chk("rstw/mem_addr", 32'(mem_addr), 0);
        chk("rstw/mem_wdata", 32'(mem_wdata), 0);
        chk("rstw/resp_valid", 32'(resp_valid), 0);
        chk("rstw/busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rstw/req_ready", 32'(req_ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw/no_resp", 32'(resp_valid), 0);
        end
        chk("rstw/word_kept", 32'(dev_mem[16]), 32'(ref_mem[16]));

        run_txn("post_rst_load", 1'b0, 8'h10, 8'h00, 16'h0, 1'b0, 8'h10, 0);

        @(negedge clk);
        chk("enable_count", 32'(seen_en), 32'(exp_en));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
